apb_master: RTL

//  APB requester that drives the PSEL/PENABLE/PWRITE/PADDR/PWDATA side of an
//  APB bus and pairs with our apb_slave memory block (8 x 32-bit registers).

---
 rtl/apb_master_if.sv | 34 +++
 rtl/apb_master.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/apb_master_if.sv
// Command/response and APB bus signals shared by apb_master and whatever it talks to.
// The master modport is the requester's view; the slave modport is the mirror image.
interface apb_master_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_err;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
    output cmd_ready, rsp_valid, rsp_err, rsp_rdata,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
    input  cmd_ready, rsp_valid, rsp_err, rsp_rdata,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_master.sv
// APB requester: one cmd_valid/cmd_ready request becomes one APB transfer and one
// rsp_valid pulse; a wait-state timeout aborts transfers to a slave that never answers.
module apb_master #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input logic          PCLK,
  input logic          PRESETn,
  apb_master_if.master bus
);

  // state  | meaning
  // IDLE   | bus idle, cmd_ready high, waiting for a request
  // SETUP  | PSEL high, PENABLE low, address/data presented
  // ACCESS | PSEL and PENABLE high, waiting for PREADY or timeout
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int LAST_I = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = LAST_I[CNT_W-1:0];

  state_t                r_state;
  logic                  r_psel;
  logic                  r_penable;
  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic                  r_rsp_valid;
  logic                  r_rsp_err;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic [CNT_W-1:0]      r_wait_cnt;

  state_t                w_state_nxt;
  logic                  w_psel_nxt;
  logic                  w_penable_nxt;
  logic                  w_pwrite_nxt;
  logic [ADDR_WIDTH-1:0] w_paddr_nxt;
  logic [DATA_WIDTH-1:0] w_pwdata_nxt;
  logic                  w_rsp_valid_nxt;
  logic                  w_rsp_err_nxt;
  logic [DATA_WIDTH-1:0] w_rsp_rdata_nxt;
  logic [CNT_W-1:0]      w_wait_cnt_nxt;
  logic                  w_timeout_hit;

  assign w_timeout_hit = (TIMEOUT != 0) && (r_wait_cnt == CNT_LAST);

  always_comb begin
    w_state_nxt     = r_state;
    w_psel_nxt      = r_psel;
    w_penable_nxt   = r_penable;
    w_pwrite_nxt    = r_pwrite;
    w_paddr_nxt     = r_paddr;
    w_pwdata_nxt    = r_pwdata;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_err_nxt   = 1'b0;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_wait_cnt_nxt  = r_wait_cnt;

    unique case (r_state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          w_state_nxt   = ST_SETUP;
          w_psel_nxt    = 1'b1;
          w_penable_nxt = 1'b0;
          w_pwrite_nxt  = bus.cmd_write;
          w_paddr_nxt   = bus.cmd_addr;
          w_pwdata_nxt  = bus.cmd_wdata;
        end
      end

      ST_SETUP: begin
        w_state_nxt    = ST_ACCESS;
        w_penable_nxt  = 1'b1;
        w_wait_cnt_nxt = '0;
      end

      ST_ACCESS: begin
        if (bus.PREADY) begin
          w_state_nxt     = ST_IDLE;
          w_psel_nxt      = 1'b0;
          w_penable_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          if (!r_pwrite) begin
            w_rsp_rdata_nxt = bus.PRDATA;
          end
        end else if (w_timeout_hit) begin
          w_state_nxt     = ST_IDLE;
          w_psel_nxt      = 1'b0;
          w_penable_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b1;
          if (!r_pwrite) begin
            w_rsp_rdata_nxt = '0;
          end
        end else if (TIMEOUT != 0) begin
          // With the timeout disabled the counter is parked so it never wraps.
          w_wait_cnt_nxt = r_wait_cnt + 1'b1;
        end
      end

      default: begin
        w_state_nxt   = ST_IDLE;
        w_psel_nxt    = 1'b0;
        w_penable_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state     <= ST_IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_wait_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_pwrite    <= w_pwrite_nxt;
      r_paddr     <= w_paddr_nxt;
      r_pwdata    <= w_pwdata_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
    end
  end

  assign bus.cmd_ready = (r_state == ST_IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.PSEL      = r_psel;
  assign bus.PENABLE   = r_penable;
  assign bus.PWRITE    = r_pwrite;
  assign bus.PADDR     = r_paddr;
  assign bus.PWDATA    = r_pwdata;

endmodule
